// File: rtl/int_div_core.sv
// int_div_core: sequential unsigned restoring divider, one quotient bit per clock.
// Results and status are registered; start is accepted in IDLE and FIN only.
`default_nettype none

module int_div_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   localparam int            CW     = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST   = CW'(WIDTH);
   localparam logic [1:0]    S_IDLE = 2'd0;
   localparam logic [1:0]    S_RUN  = 2'd1;
   localparam logic [1:0]    S_FIN  = 2'd2;

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dsr;
   logic [WIDTH-1:0] rem;
   logic             zero_div;

   logic [WIDTH:0]   rem_ext;
   logic [WIDTH:0]   diff;
   logic             ge;
   logic [WIDTH-1:0] rem_next;

   // One extra bit on the trial subtraction keeps the shifted-out MSB of rem.
   always_comb begin
      rem_ext  = {rem, dvd[WIDTH-1]};
      diff     = rem_ext - {1'b0, dsr};
      ge       = (rem_ext >= {1'b0, dsr});
      rem_next = ge ? diff[WIDTH-1:0] : rem_ext[WIDTH-1:0];
   end

   assign busy = (state == S_RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         dvd         <= '0;
         dsr         <= '0;
         rem         <= '0;
         zero_div    <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_FIN: begin
               if (start) begin
                  dvd         <= dividend;
                  dsr         <= divisor;
                  rem         <= '0;
                  cnt         <= '0;
                  zero_div    <= (divisor == '0);
                  quotient    <= '0;
                  remainder   <= '0;
                  div_by_zero <= 1'b0;
                  state       <= S_RUN;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               if (zero_div) begin
                  quotient    <= '1;
                  remainder   <= dvd;
                  div_by_zero <= 1'b1;
                  done        <= 1'b1;
                  state       <= S_FIN;
               end else if (cnt == LAST) begin
                  // Quotient bits have been shifted into dvd as its MSBs left.
                  quotient  <= dvd;
                  remainder <= rem;
                  done      <= 1'b1;
                  state     <= S_FIN;
               end else begin
                  rem <= rem_next;
                  dvd <= {dvd[WIDTH-2:0], ge};
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
